core_mmio_initiator: RTL and testbench
======================================

# core_mmio_initiator

Core-side initiator for the memory-mapped IO bus that the counter/timer peripheral and other MMIO responders sit on. Accepts one load or store at a time from the load/store pipeline stage, range- and alignment-checks it, drives the request/grant handshake, and captures the registered read data and error. It returns a single size-adjusted response to the pipeline. It also enforces a grant timeout, handles pipeline flushes, and guarantees that an accepted bus transfer is never torn.

## Interface
Parameters:
- MMIO_BASE, 39'd0, base address of the MMIO window.
- MMIO_SIZE, 39'd4096, window size in bytes; power of two.
- GNT_TIMEOUT, 16, cycles to wait for mmio_gnt before aborting; ≥1, counter sized by $clog2(GNT_TIMEOUT+1).

Ports:
- g_clk  in  1  clock; all state updates on rising edge.
- g_resetn  in  1  reset; synchronous, active-low.
- lsu_valid  in  1  pipeline presents an access.
- lsu_ready  out  1  block can accept; high only in IDLE.
- lsu_wen  in  1  1 = store, 0 = load.
- lsu_addr  in  39  byte address.
- lsu_wdata  in  64  store data.
- lsu_size  in  2  0=byte,1=half,2=word,3=double.
- lsu_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
- lsu_prv  in  2  {machine, user} privilege, passed to mmio_prv.
- flush  in  1  discard the in-flight access.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  pipeline consumes response.
- rsp_rdata  out  64  extended load data; 0 for stores and errors.
- rsp_error  out  1  access fault.
- mmio_req, mmio_wen  out  1  bus request / write enable.
- mmio_addr  out  39;  mmio_wdata  out  64;  mmio_prv  out  2.
- mmio_gnt  in  1;  mmio_rdata  in  64;  mmio_error  in  1.

## Operation
- States: IDLE, REQ, RSP, HOLD. Reset → IDLE. All outputs are 0 in reset and in IDLE, except lsu_ready=1 in IDLE.
- IDLE: on lsu_valid, capture address, data, size, flags and prv.
  - Fault if the address is outside [MMIO_BASE, MMIO_BASE+MMIO_SIZE), or is misaligned for its size (addr[size-1:0]≠0), or is a store with size≠3.
  - On fault → HOLD with error=1 and no bus activity; otherwise → REQ.
- REQ: mmio_req=1, with mmio_addr = {addr[38:3],3'b0} and the captured wen/wdata/prv.
  - mmio_gnt=1 → RSP.
  - Timeout counter reaches GNT_TIMEOUT-1 without grant → HOLD with error=1.
  - Counter clears on every REQ entry.
- RSP: mmio_req=0. Sample mmio_rdata/mmio_error this cycle → HOLD.
- HOLD: rsp_valid=1; data/error stable until rsp_ready → IDLE.
- Load data: shift the doubleword right by addr[2:0]*8, mask to size, then sign- or zero-extend to 64. Size 3 passes through unchanged.
- On mmio_error=1, rsp_rdata=0 and rsp_error=1.
- flush:
  - In REQ → IDLE immediately, mmio_req drops next cycle.
  - In RSP → the bus response is consumed silently, then IDLE; no rsp_valid.
  - In HOLD → IDLE, response dropped.
  - In IDLE it is ignored, and an access presented in the same cycle is not accepted.
- flush and mmio_gnt in the same REQ cycle: the grant is honoured (transfer completes on the bus) and the result is discarded via RSP → IDLE.
- Reset mid-transfer returns to IDLE; no outputs held.

## Timing
- Zero-wait grant: accept in cycle N, mmio_req high in N+1, RSP in N+2, rsp_valid in N+3.
- Each wait cycle of mmio_gnt=0 adds one cycle.
- Early faults: rsp_valid in N+1.
- Timeout: mmio_req is high for exactly GNT_TIMEOUT cycles, then rsp_valid on the next cycle.
- mmio_req/addr/wen/wdata/prv are registered, and stable while mmio_req=1.
- At most one outstanding bus transfer. Back-to-back throughput is one access per 4 cycles.

## Test plan
- Load double at MMIO_BASE+8 (mtimecmp after reset = all ones), gnt tied 1 → rsp_valid at N+3, rdata=64'hFFFF_FFFF_FFFF_FFFF, error=0.
- Signed byte load at offset 0x0B, responder returns 64'h0000_0000_8000_0000 → rdata=64'hFFFF_FFFF_FFFF_FF80; with lsu_unsigned=1 → 64'h80.
- Store size 2, or half-load at odd address, or addr=MMIO_BASE+MMIO_SIZE → rsp_valid at N+1, error=1, mmio_req never asserted.
- GNT_TIMEOUT=4, gnt held 0 → mmio_req high for exactly 4 cycles, then rsp_valid with error=1 and rdata=0.
- Flush asserted in the same cycle as gnt → mmio_req for one cycle, no rsp_valid, lsu_ready=1 two cycles later. Flush asserted while in HOLD → rsp_valid drops next cycle.
- User-mode (prv=2'b01) store, responder returns mmio_error=1 → rsp_error=1, rdata=0. rsp_ready held 0 for 5 cycles → response remains stable and lsu_ready stays 0.

Source files
------------

// File: rtl/core_mmio_initiator.sv
// core_mmio_initiator: core-side MMIO bus initiator. Accepts one load/store
// from the LSU, checks range/alignment/store size, performs a req/gnt
// transfer with a grant timeout, and returns one size-extended response.
//
// Ports:
//   g_clk, g_resetn           clock, synchronous active-low reset
//   lsu_valid/lsu_ready       access handshake (ready only in IDLE)
//   lsu_wen/addr/wdata/size   access description
//   lsu_unsigned, lsu_prv     load extension mode, privilege
//   flush                     discard the in-flight access
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata, rsp_error      extended load data, access fault
//   mmio_req/wen/addr/wdata/prv  registered bus request
//   mmio_gnt/rdata/error      bus grant and registered response
module core_mmio_initiator #(
  parameter logic [38:0] MMIO_BASE   = 39'd0,
  parameter logic [38:0] MMIO_SIZE   = 39'd4096,
  parameter int unsigned GNT_TIMEOUT = 16
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_wen,
  input  logic [38:0] lsu_addr,
  input  logic [63:0] lsu_wdata,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [1:0]  lsu_prv,
  input  logic        flush,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mmio_req,
  output logic        mmio_wen,
  output logic [38:0] mmio_addr,
  output logic [63:0] mmio_wdata,
  output logic [1:0]  mmio_prv,
  input  logic        mmio_gnt,
  input  logic [63:0] mmio_rdata,
  input  logic        mmio_error
);

  localparam int unsigned AW = 39;
  localparam int unsigned DW = 64;
  localparam int unsigned CW = $clog2(GNT_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            wen_q, wen_d;
  logic            discard_q, discard_d;
  logic            lsu_ready_q, lsu_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_error_q, rsp_error_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            mmio_req_q, mmio_req_d;
  logic            mmio_wen_q, mmio_wen_d;
  logic [AW-1:0]   mmio_addr_q, mmio_addr_d;
  logic [DW-1:0]   mmio_wdata_q, mmio_wdata_d;
  logic [1:0]      mmio_prv_q, mmio_prv_d;

  // Access check on the presented request (one extra bit avoids wrap at the window top)
  logic [AW:0] addr_ext_c, lo_ext_c, hi_ext_c;
  logic        misalign_c, fault_c;

  assign addr_ext_c = {1'b0, lsu_addr};
  assign lo_ext_c   = {1'b0, MMIO_BASE};
  assign hi_ext_c   = lo_ext_c + {1'b0, MMIO_SIZE};

  always_comb begin
    misalign_c = 1'b0;
    case (lsu_size)
      2'd0:    misalign_c = 1'b0;
      2'd1:    misalign_c = lsu_addr[0];
      2'd2:    misalign_c = |lsu_addr[1:0];
      default: misalign_c = |lsu_addr[2:0];
    endcase
  end

  assign fault_c = (addr_ext_c < lo_ext_c) || (addr_ext_c >= hi_ext_c) || misalign_c ||
                   (lsu_wen && (lsu_size != 2'd3));

  // Load data alignment and extension from the bus doubleword
  logic [DW-1:0] shifted_c, load_ext_c;
  assign shifted_c = mmio_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext_c = shifted_c;
    case (size_q)
      2'd0:    load_ext_c = {{56{~uns_q & shifted_c[7]}},  shifted_c[7:0]};
      2'd1:    load_ext_c = {{48{~uns_q & shifted_c[15]}}, shifted_c[15:0]};
      2'd2:    load_ext_c = {{32{~uns_q & shifted_c[31]}}, shifted_c[31:0]};
      default: load_ext_c = shifted_c;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    wen_d        = wen_q;
    discard_d    = discard_q;
    lsu_ready_d  = lsu_ready_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_error_d  = rsp_error_q;
    rsp_rdata_d  = rsp_rdata_q;
    mmio_req_d   = mmio_req_q;
    mmio_wen_d   = mmio_wen_q;
    mmio_addr_d  = mmio_addr_q;
    mmio_wdata_d = mmio_wdata_q;
    mmio_prv_d   = mmio_prv_q;

    case (state_q)
      S_IDLE: begin
        // flush in IDLE blocks acceptance for that cycle
        if (lsu_valid && !flush) begin
          off_d       = lsu_addr[2:0];
          size_d      = lsu_size;
          uns_d       = lsu_unsigned;
          wen_d       = lsu_wen;
          discard_d   = 1'b0;
          lsu_ready_d = 1'b0;
          if (fault_c) begin
            state_d     = S_HOLD;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d      = S_REQ;
            cnt_d        = '0;
            mmio_req_d   = 1'b1;
            mmio_wen_d   = lsu_wen;
            mmio_addr_d  = {lsu_addr[AW-1:3], 3'b000};
            mmio_wdata_d = lsu_wdata;
            mmio_prv_d   = lsu_prv;
          end
        end
      end
      S_REQ: begin
        // A grant wins over flush so an accepted transfer is never torn
        if (mmio_gnt) begin
          state_d   = S_RSP;
          discard_d = flush;
        end else if (flush) begin
          state_d     = S_IDLE;
          lsu_ready_d = 1'b1;
        end else if (cnt_q == CW'(GNT_TIMEOUT - 1)) begin
          state_d     = S_HOLD;
          rsp_valid_d = 1'b1;
          rsp_error_d = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RSP: begin
        if (discard_q || flush) begin
          state_d     = S_IDLE;
          lsu_ready_d = 1'b1;
        end else begin
          state_d     = S_HOLD;
          rsp_valid_d = 1'b1;
          rsp_error_d = mmio_error;
          rsp_rdata_d = (mmio_error || wen_q) ? '0 : load_ext_c;
        end
      end
      default: begin
        if (rsp_ready || flush) begin
          state_d     = S_IDLE;
          lsu_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_error_d = 1'b0;
          rsp_rdata_d = '0;
        end
      end
    endcase

    // Bus outputs are only non-zero while requesting
    if (state_d != S_REQ) begin
      mmio_req_d   = 1'b0;
      mmio_wen_d   = 1'b0;
      mmio_addr_d  = '0;
      mmio_wdata_d = '0;
      mmio_prv_d   = '0;
    end
  end

  // State and output registers
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      wen_q        <= 1'b0;
      discard_q    <= 1'b0;
      lsu_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      mmio_req_q   <= 1'b0;
      mmio_wen_q   <= 1'b0;
      mmio_addr_q  <= '0;
      mmio_wdata_q <= '0;
      mmio_prv_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      wen_q        <= wen_d;
      discard_q    <= discard_d;
      lsu_ready_q  <= lsu_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      rsp_rdata_q  <= rsp_rdata_d;
      mmio_req_q   <= mmio_req_d;
      mmio_wen_q   <= mmio_wen_d;
      mmio_addr_q  <= mmio_addr_d;
      mmio_wdata_q <= mmio_wdata_d;
      mmio_prv_q   <= mmio_prv_d;
    end
  end

  assign lsu_ready  = lsu_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_error  = rsp_error_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign mmio_req   = mmio_req_q;
  assign mmio_wen   = mmio_wen_q;
  assign mmio_addr  = mmio_addr_q;
  assign mmio_wdata = mmio_wdata_q;
  assign mmio_prv   = mmio_prv_q;

endmodule

// File: tb/tb_core_mmio_initiator.sv
// Randomized bench for core_mmio_initiator with a transaction-level model.
module tb_core_mmio_initiator;

  localparam logic [38:0] BASE = 39'h0000_10_0000;
  localparam logic [38:0] SIZE = 39'd4096;
  localparam int          TO   = 4;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        lsu_valid, lsu_ready, lsu_wen, lsu_unsigned, flush;
  logic [38:0] lsu_addr;
  logic [63:0] lsu_wdata;
  logic [1:0]  lsu_size, lsu_prv;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [63:0] rsp_rdata;
  logic        mmio_req, mmio_wen, mmio_gnt, mmio_error;
  logic [38:0] mmio_addr;
  logic [63:0] mmio_wdata, mmio_rdata;
  logic [1:0]  mmio_prv;

  int total = 0;
  int bad   = 0;

  core_mmio_initiator #(.MMIO_BASE(BASE), .MMIO_SIZE(SIZE), .GNT_TIMEOUT(TO)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_prv(lsu_prv), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mmio_req(mmio_req), .mmio_wen(mmio_wen),
    .mmio_addr(mmio_addr), .mmio_wdata(mmio_wdata), .mmio_prv(mmio_prv),
    .mmio_gnt(mmio_gnt), .mmio_rdata(mmio_rdata), .mmio_error(mmio_error)
  );

  always #5 g_clk = ~g_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: access legality from the address window and natural alignment
  function automatic logic model_fault(input logic [38:0] a, input logic [1:0] sz, input logic w);
    longint unsigned ua, lo, hi, nb;
    ua = longint'(a);
    lo = longint'(BASE);
    hi = lo + longint'(SIZE);
    nb = longint'(1) << sz;
    return (ua < lo) || (ua >= hi) || ((ua % nb) != 0) || (w && sz != 2'd3);
  endfunction

  // Reference: gather little-endian bytes, then extend
  function automatic logic [63:0] model_load(input logic [63:0] dw, input logic [2:0] off,
                                             input logic [1:0] sz, input logic uns);
    int nb, o;
    logic [63:0] v;
    nb = 1 << sz;
    o  = int'(off);
    v  = '0;
    for (int b = nb - 1; b >= 0; b--) v = (v << 8) | 64'(dw[(o + b) * 8 +: 8]);
    if (!uns && nb < 8 && v[nb * 8 - 1]) v = v | (~64'd0 << (nb * 8));
    return v;
  endfunction

  // fmode: 0 none, 1 flush with grant, 2 flush in REQ without grant,
  //        3 flush in HOLD, 4 flush in RSP, 5 flush in IDLE with valid
  task automatic txn(input logic w, input logic [38:0] a, input logic [63:0] wd,
                     input logic [1:0] sz, input logic uns, input logic [1:0] prv,
                     input int gdly, input logic [63:0] bus_d, input logic bus_e,
                     input int fmode, input int hold, output logic [63:0] got);
    logic fault, granted, exp_e;
    logic [63:0] exp_d;
    fault   = model_fault(a, sz, w);
    granted = 1'b0;
    got     = '0;
    @(negedge g_clk);
    check("ready_idle", 64'(lsu_ready), 64'd1);
    lsu_valid = 1'b1; lsu_wen = w; lsu_addr = a; lsu_wdata = wd;
    lsu_size = sz; lsu_unsigned = uns; lsu_prv = prv; flush = (fmode == 5);
    @(negedge g_clk);
    lsu_valid = 1'b0; flush = 1'b0;
    lsu_addr = 39'({$urandom, $urandom}); lsu_wdata = {$urandom, $urandom};
    lsu_wen = 1'($urandom); lsu_size = 2'($urandom); lsu_prv = 2'($urandom);
    if (fmode == 5) begin
      check("iflush_ready", 64'(lsu_ready), 64'd1);
      check("iflush_req", 64'(mmio_req), 64'd0);
      check("iflush_rv", 64'(rsp_valid), 64'd0);
      return;
    end
    if (fault) begin
      exp_e = 1'b1; exp_d = '0;
    end else begin
      for (int i = 0; i < TO; i++) begin
        check("req_hi", 64'(mmio_req), 64'd1);
        check("req_addr", 64'(mmio_addr), 64'({a[38:3], 3'b000}));
        check("req_wen", 64'(mmio_wen), 64'(w));
        check("req_wdata", mmio_wdata, wd);
        check("req_prv", 64'(mmio_prv), 64'(prv));
        check("req_rv", 64'(rsp_valid), 64'd0);
        mmio_rdata = {$urandom, $urandom}; mmio_error = 1'($urandom);
        if (fmode == 2 && i == gdly) begin
          flush = 1'b1;
          @(negedge g_clk);
          flush = 1'b0;
          check("rflush_req", 64'(mmio_req), 64'd0);
          check("rflush_ready", 64'(lsu_ready), 64'd1);
          check("rflush_rv", 64'(rsp_valid), 64'd0);
          return;
        end
        mmio_gnt = (i == gdly);
        flush    = (fmode == 1 && i == gdly);
        @(negedge g_clk);
        mmio_gnt = 1'b0; flush = 1'b0;
        if (i == gdly) begin
          granted = 1'b1;
          break;
        end
      end
      if (granted) begin
        check("rsp_req", 64'(mmio_req), 64'd0);
        check("rsp_rv", 64'(rsp_valid), 64'd0);
        mmio_rdata = bus_d; mmio_error = bus_e; flush = (fmode == 4);
        @(negedge g_clk);
        mmio_rdata = {$urandom, $urandom}; mmio_error = 1'($urandom); flush = 1'b0;
        if (fmode == 1 || fmode == 4) begin
          check("dflush_rv", 64'(rsp_valid), 64'd0);
          check("dflush_ready", 64'(lsu_ready), 64'd1);
          return;
        end
        exp_e = bus_e;
        exp_d = (bus_e || w) ? 64'd0 : model_load(bus_d, a[2:0], sz, uns);
      end else begin
        exp_e = 1'b1; exp_d = '0;
      end
    end
    got = rsp_rdata;
    check("hold_rv", 64'(rsp_valid), 64'd1);
    check("hold_err", 64'(rsp_error), 64'(exp_e));
    check("hold_data", rsp_rdata, exp_d);
    check("hold_req", 64'(mmio_req), 64'd0);
    check("hold_ready", 64'(lsu_ready), 64'd0);
    if (fmode == 3) begin
      flush = 1'b1;
      @(negedge g_clk);
      flush = 1'b0;
      check("hflush_rv", 64'(rsp_valid), 64'd0);
      check("hflush_ready", 64'(lsu_ready), 64'd1);
      return;
    end
    for (int k = 0; k < hold; k++) begin
      @(negedge g_clk);
      check("stall_rv", 64'(rsp_valid), 64'd1);
      check("stall_data", rsp_rdata, exp_d);
      check("stall_err", 64'(rsp_error), 64'(exp_e));
      check("stall_ready", 64'(lsu_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge g_clk);
    rsp_ready = 1'b0;
    check("done_rv", 64'(rsp_valid), 64'd0);
    check("done_data", rsp_rdata, 64'd0);
    check("done_ready", 64'(lsu_ready), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] got;
    g_resetn = 1'b0; lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0;
    lsu_size = '0; lsu_unsigned = 1'b0; lsu_prv = '0; flush = 1'b0; rsp_ready = 1'b0;
    mmio_gnt = 1'b0; mmio_rdata = '0; mmio_error = 1'b0;
    repeat (3) @(negedge g_clk);
    check("rst_rv", 64'(rsp_valid), 64'd0);
    check("rst_req", 64'(mmio_req), 64'd0);
    check("rst_data", rsp_rdata, 64'd0);
    g_resetn = 1'b1;

    // Directed scenarios
    txn(1'b0, BASE + 39'd8, 64'd0, 2'd3, 1'b0, 2'b10, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, 0, got);
    check("mtimecmp", got, 64'hFFFF_FFFF_FFFF_FFFF);
    txn(1'b0, BASE + 39'h0B, 64'd0, 2'd0, 1'b0, 2'b10, 1, 64'h0000_0000_8000_0000, 1'b0, 0, 1, got);
    check("sbyte", got, 64'hFFFF_FFFF_FFFF_FF80);
    txn(1'b0, BASE + 39'h0B, 64'd0, 2'd0, 1'b1, 2'b10, 0, 64'h0000_0000_8000_0000, 1'b0, 0, 0, got);
    check("ubyte", got, 64'h80);
    txn(1'b1, BASE, 64'h1234, 2'd2, 1'b0, 2'b10, 0, 64'd0, 1'b0, 0, 0, got);
    txn(1'b0, BASE + 39'd3, 64'd0, 2'd1, 1'b0, 2'b10, 0, 64'd0, 1'b0, 0, 0, got);
    txn(1'b0, BASE + SIZE, 64'd0, 2'd3, 1'b0, 2'b10, 0, 64'd0, 1'b0, 0, 0, got);
    txn(1'b0, BASE + 39'd16, 64'd0, 2'd3, 1'b0, 2'b10, 99, 64'd0, 1'b0, 0, 0, got);
    txn(1'b0, BASE + 39'd16, 64'd0, 2'd3, 1'b0, 2'b10, 1, 64'h55, 1'b0, 1, 0, got);
    txn(1'b0, BASE + 39'd16, 64'd0, 2'd3, 1'b0, 2'b10, 0, 64'h55, 1'b0, 3, 0, got);
    txn(1'b1, BASE + 39'd24, 64'hDEAD_BEEF_0000_0001, 2'd3, 1'b0, 2'b01, 0, 64'h77, 1'b1, 0, 5, got);
    check("user_err_data", got, 64'd0);

    // Reset mid-transfer
    @(negedge g_clk);
    lsu_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = BASE; lsu_size = 2'd3;
    @(negedge g_clk);
    lsu_valid = 1'b0;
    check("mid_req", 64'(mmio_req), 64'd1);
    g_resetn = 1'b0;
    @(negedge g_clk);
    check("mid_rst_req", 64'(mmio_req), 64'd0);
    check("mid_rst_rv", 64'(rsp_valid), 64'd0);
    g_resetn = 1'b1;

    // Randomized accesses
    for (int n = 0; n < 300; n++) begin
      logic w, u;
      logic [1:0] sz, pv;
      logic [38:0] a;
      int pick, fm;
      w  = ($urandom_range(0, 2) == 0);
      sz = w ? (($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd3) : 2'($urandom);
      u  = 1'($urandom);
      pv = 2'($urandom);
      pick = $urandom_range(0, 9);
      if (pick <= 5)      a = BASE + (39'($urandom_range(0, 4095)) & ~((39'd1 << sz) - 39'd1));
      else if (pick == 6) a = BASE + 39'($urandom_range(0, 4095));
      else if (pick == 7) a = BASE - 39'($urandom_range(1, 64));
      else if (pick == 8) a = BASE + SIZE + 39'($urandom_range(0, 64));
      else                a = 39'({$urandom, $urandom});
      fm = $urandom_range(0, 11);
      if (fm > 5) fm = 0;
      txn(w, a, {$urandom, $urandom}, sz, u, pv, $urandom_range(0, 5),
          {$urandom, $urandom}, ($urandom_range(0, 4) == 0), fm, $urandom_range(0, 3), got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
